// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//   Age-ordered issue queue for the single-cycle add/logic unit. Entries sit in
//   a shifting array (index 0 oldest), wait for their sources on the CDB, issue
//   oldest-ready-first to the unit and park the result in a one-deep output
//   register until the CDB arbiter grants it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop every queued entry and the pending result
//   dispatch_*               dispatch handshake and instruction payload
//   cdb_valid/paddr/v        result broadcast used for operand wakeup
//   fu_start, fu_*           issue to the unit; fu_rd_v returns in-cycle
//   out_*                    registered result waiting for the CDB
//   cdb_grant                arbiter accepted out_* this cycle
//   perf_issue_cnt/full_cnt  saturating counters, only with ALU_IQ_PERF_EN
//
// Build option: define ALU_IQ_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------

package alu_issue_queue_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  // Decoded ALU instruction; imm replaces rs2 when use_imm is set.
  typedef struct packed {
    alu_op_e     op;
    logic        use_imm;
    logic [31:0] imm;
  } decode_info_t;

endpackage

module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned PHYS_REG_BITS = 6,
  parameter int unsigned ROB_IDX_BITS  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  decode_info_t             dispatch_decode_info,
  input  logic [PHYS_REG_BITS-1:0] dispatch_rs1_paddr,
  input  logic [PHYS_REG_BITS-1:0] dispatch_rs2_paddr,
  input  logic                     dispatch_rs1_rdy,
  input  logic                     dispatch_rs2_rdy,
  input  logic [31:0]              dispatch_rs1_v,
  input  logic [31:0]              dispatch_rs2_v,
  input  logic [PHYS_REG_BITS-1:0] dispatch_rd_paddr,
  input  logic [ROB_IDX_BITS-1:0]  dispatch_rob_idx,
  input  logic                     cdb_valid,
  input  logic [PHYS_REG_BITS-1:0] cdb_paddr,
  input  logic [31:0]              cdb_v,
  output logic                     fu_start,
  output logic [31:0]              fu_rs1_v,
  output logic [31:0]              fu_rs2_v,
  output decode_info_t             fu_decode_info,
  input  logic [31:0]              fu_rd_v,
  output logic                     out_valid,
  output logic [PHYS_REG_BITS-1:0] out_rd_paddr,
  output logic [ROB_IDX_BITS-1:0]  out_rob_idx,
  output logic [31:0]              out_rd_v,
  input  logic                     cdb_grant
`ifdef ALU_IQ_PERF_EN
  ,
  output logic [31:0]              perf_issue_cnt,
  output logic [31:0]              perf_full_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    decode_info_t             info;
    logic [PHYS_REG_BITS-1:0] rs1_tag;
    logic                     rs1_rdy;
    logic [31:0]              rs1_v;
    logic [PHYS_REG_BITS-1:0] rs2_tag;
    logic                     rs2_rdy;
    logic [31:0]              rs2_v;
    logic [PHYS_REG_BITS-1:0] rd_paddr;
    logic [ROB_IDX_BITS-1:0]  rob_idx;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woken [DEPTH];
  entry_t           new_ent;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] tail;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             slot_free;
  logic             issue;
  logic             accept;
  logic             wake;

  // Oldest entry with both operands ready, gated by the output slot.
  always_comb begin
    slot_free = !out_valid || cdb_grant;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count_q) && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    issue = !rst && !flush && slot_free && sel_found;
  end

  // Issue port is zeroed when idle so the unit never sees stale operands.
  always_comb begin
    fu_start       = issue;
    fu_rs1_v       = '0;
    fu_rs2_v       = '0;
    fu_decode_info = '0;
    if (issue) begin
      fu_rs1_v       = ent_q[sel_idx].rs1_v;
      fu_rs2_v       = ent_q[sel_idx].rs2_v;
      fu_decode_info = ent_q[sel_idx].info;
    end
  end

  assign dispatch_ready = !rst && (count_q < CNT_W'(DEPTH));
  assign accept         = dispatch_valid && dispatch_ready && !flush;
  assign wake           = cdb_valid && !flush;

  // Next queue image: wakeup, then compaction past the issued slot, then tail write.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      woken[i] = ent_q[i];
      if (wake && (CNT_W'(i) < count_q)) begin
        if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_paddr)) begin
          woken[i].rs1_rdy = 1'b1;
          woken[i].rs1_v   = cdb_v;
        end
        if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_paddr)) begin
          woken[i].rs2_rdy = 1'b1;
          woken[i].rs2_v   = cdb_v;
        end
      end
    end

    new_ent.info     = dispatch_decode_info;
    new_ent.rs1_tag  = dispatch_rs1_paddr;
    new_ent.rs1_rdy  = dispatch_rs1_rdy;
    new_ent.rs1_v    = dispatch_rs1_v;
    new_ent.rs2_tag  = dispatch_rs2_paddr;
    new_ent.rs2_rdy  = dispatch_rs2_rdy;
    new_ent.rs2_v    = dispatch_rs2_v;
    new_ent.rd_paddr = dispatch_rd_paddr;
    new_ent.rob_idx  = dispatch_rob_idx;
    // A broadcast in the dispatch cycle must not be missed by the new entry.
    if (wake && !dispatch_rs1_rdy && (dispatch_rs1_paddr == cdb_paddr)) begin
      new_ent.rs1_rdy = 1'b1;
      new_ent.rs1_v   = cdb_v;
    end
    if (wake && !dispatch_rs2_rdy && (dispatch_rs2_paddr == cdb_paddr)) begin
      new_ent.rs2_rdy = 1'b1;
      new_ent.rs2_v   = cdb_v;
    end

    ent_d = woken;
    if (issue) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          ent_d[i] = woken[i + 1];
        end
      end
    end

    tail = count_q - CNT_W'(issue);
    if (accept) begin
      ent_d[IDX_W'(tail)] = new_ent;
    end

    count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
    if (flush) begin
      count_d = '0;
    end
  end

  // Queue state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  // One-deep result register toward the CDB; holds until granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_rd_v     <= '0;
      out_rd_paddr <= '0;
      out_rob_idx  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid    <= 1'b1;
      out_rd_v     <= fu_rd_v;
      out_rd_paddr <= ent_q[sel_idx].rd_paddr;
      out_rob_idx  <= ent_q[sel_idx].rob_idx;
    end else if (cdb_grant) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_IQ_PERF_EN
  // Saturating counters; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (issue && (perf_issue_cnt != '1)) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
      if ((count_q == CNT_W'(DEPTH)) && dispatch_valid && (perf_full_cnt != '1)) begin
        perf_full_cnt <= perf_full_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
